regfile_wb_sched: RTL and testbench
===================================

# regfile_wb_sched

Writeback scheduler and scoreboard for the 32×32 register file. Shares the register file's single write port (WE/WAdr/Din) between two writeback sources, the ALU and the memory/load unit, using round-robin valid/ready arbitration. Tracks which registers have a write pending and stalls the issue stage on RAW or WAW hazards. Sits between the pipeline writeback paths and the register file; the register file commits writes on the falling edge of Clk.

## Interface
- DW, 32: data width
- AW, 5: register address width (2^AW registers, index 0 hardwired zero)

- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- AluValid  in  1  ALU writeback request
- AluAdr  in  AW  ALU destination register
- AluData  in  DW  ALU result
- AluReady  out  1  ALU request accepted this cycle
- MemValid  in  1  load-unit writeback request
- MemAdr  in  AW  load destination register
- MemData  in  DW  load result
- MemReady  out  1  load request accepted this cycle
- IssueValid  in  1  instruction presented at issue
- IssueWr  in  1  issuing instruction writes rd
- IssueRd / IssueRs1 / IssueRs2  in  AW  destination and source registers
- IssueStall  out  1  hazard; instruction must hold
- WE  out  1  register-file write enable (registered)
- WAdr  out  AW  register-file write address (registered)
- Din  out  DW  register-file write data (registered)
- Busy  out  2^AW  pending-write vector; bit 0 always 0

## Operation
- Handshake: a transfer occurs when Valid&Ready on a rising edge. Valid must not depend on Ready. Ready may depend combinationally on both Valids and the priority state Pri. Adr and Data stay stable while Valid&!Ready.
- Arbitration: at most one grant per cycle.
  - If only one source is valid, it is granted.
  - If both are valid, the source named by Pri is granted.
  - After any grant, Pri points to the non-granted source. With no grant, Pri holds.
  - Reset value of Pri is ALU.
- Accepted write: on that edge, WE←(Adr≠0), WAdr←Adr, Din←Data, and Busy[Adr]←0. With no grant, WE←0 and WAdr/Din hold.
- Writes to x0 are accepted (Ready asserted) but are never written (WE=0) and never touch Busy.
- Writeback to a register whose Busy bit is 0 is still written; clearing the bit is a no-op.
- Scoreboard:
  - IssueStall = IssueValid & ((Rs1≠0 & Busy[Rs1]) | (Rs2≠0 & Busy[Rs2]) | (IssueWr & Rd≠0 & Busy[Rd])).
  - On IssueValid & !IssueStall & IssueWr & Rd≠0, Busy[Rd]←1.
  - If the same index is set and cleared on one edge, set wins.
  - IssueStall uses the current-cycle Busy only; a clear on the same edge does not bypass it.
- Reset (including mid-operation): Busy←0, Pri←ALU, WE←0, WAdr←0, Din←0. A write held in the output register is dropped. AluReady=MemReady=0 and IssueStall=0 while Rst=1.

## Timing
- Accept at rising edge N: WE/WAdr/Din are valid throughout cycle N+1. The register file commits at the falling edge inside N+1.
- Busy clears at edge N. An instruction issuing in N+1 sees no stall and reads the new value after the mid-cycle falling edge, before edge N+2.
- Issue to Busy set: 1 edge. An instruction in cycle N+1 depending on Rd set at edge N stalls.
- Back-to-back grants: one per cycle, sustained. With both sources continuously valid they alternate ALU, MEM, ALU, …
- Ready, IssueStall: combinational, zero latency. All other outputs are registered.

## Structure
- Shared package: DW/AW constants, source encoding (SRC_ALU=0, SRC_MEM=1) used for Pri, and the x0 index constant.
- One natural sub-module: rr_arb2 (two-input round-robin arbiter with Pri register). Scoreboard and output register stay in the top module.

## Test plan
- Reset: assert Rst mid-write with WE=1 → next cycle WE=0, Busy=0, Pri=ALU; Ready=0 and IssueStall=0 during Rst.
- RAW stall: issue Rd=5, IssueWr=1 → Busy[5]=1. Issue Rs1=5 → IssueStall=1 until ALU writes x5=0x1234. In the following cycle stall=0 and the register file returns 0x1234.
- Contention: AluValid and MemValid held high for 4 cycles (Adr 3, 4) → grants ALU, MEM, ALU, MEM; WE high each cycle; WAdr alternates 3, 4.
- x0: MemValid, MemAdr=0, MemData=0xFFFF_FFFF → MemReady=1, WE stays 0, Busy unchanged. IssueRs1=0 never stalls.
- Simultaneous set/clear: ALU writes x7 (Busy[7]=0) on the same edge an issue sets Rd=7 → Busy[7]=1 after the edge.
- WAW: Busy[9]=1; issue with IssueWr=1, Rd=9, sources clear → IssueStall=1 until x9 writeback is accepted.

Source files
------------

// File: rtl/regfile_wb_sched_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package regfile_wb_sched_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32'(1) << AW;

    typedef logic [AW-1:0] radr_t;
    typedef logic [DW-1:0] data_t;

    // Writeback source encoding, also used as the round-robin priority state
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    localparam radr_t X0_IDX = '0;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Writeback, issue and register-file signals of the writeback scheduler.
interface regfile_wb_sched_if;
    import regfile_wb_sched_pkg::*;

    logic            AluValid;
    radr_t           AluAdr;
    data_t           AluData;
    logic            AluReady;
    logic            MemValid;
    radr_t           MemAdr;
    data_t           MemData;
    logic            MemReady;
    logic            IssueValid;
    logic            IssueWr;
    radr_t           IssueRd;
    radr_t           IssueRs1;
    radr_t           IssueRs2;
    logic            IssueStall;
    logic            WE;
    radr_t           WAdr;
    data_t           Din;
    logic [NREG-1:0] Busy;

    // Pipeline side: presents writebacks and issuing instructions
    modport master (
        output AluValid, AluAdr, AluData, MemValid, MemAdr, MemData,
        output IssueValid, IssueWr, IssueRd, IssueRs1, IssueRs2,
        input  AluReady, MemReady, IssueStall, WE, WAdr, Din, Busy
    );

    // Scheduler side
    modport slave (
        input  AluValid, AluAdr, AluData, MemValid, MemAdr, MemData,
        input  IssueValid, IssueWr, IssueRd, IssueRs1, IssueRs2,
        output AluReady, MemReady, IssueStall, WE, WAdr, Din, Busy
    );

endinterface

// File: rtl/regfile_wb_sched_rr_arb2.sv
// Two-input round-robin arbiter; grants are combinational, priority is registered.
module regfile_wb_sched_rr_arb2
    import regfile_wb_sched_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic req_alu_i,
    input  logic req_mem_i,
    output logic gnt_alu_c_o,
    output logic gnt_mem_c_o
);

    src_e pri_q;
    src_e pri_d;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pri_q <= SRC_ALU;
        end else begin
            pri_q <= pri_d;
        end
    end

    // Priority moves to the loser after every grant; nothing is granted in reset
    always_comb begin
        pri_d       = pri_q;
        gnt_alu_c_o = 1'b0;
        gnt_mem_c_o = 1'b0;
        if (!Rst) begin
            if (req_alu_i && (!req_mem_i || pri_q == SRC_ALU)) begin
                gnt_alu_c_o = 1'b1;
                pri_d       = SRC_MEM;
            end else if (req_mem_i) begin
                gnt_mem_c_o = 1'b1;
                pri_d       = SRC_ALU;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: arbitrates the register-file write port between ALU and
// load unit and keeps a pending-write scoreboard that stalls issue on RAW/WAW.
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst,
    regfile_wb_sched_if.slave  bus
);

    logic            gnt_alu;
    logic            gnt_mem;
    logic            acc;
    radr_t           acc_adr;
    data_t           acc_data;
    logic            stall;
    logic            issue_set;

    logic [NREG-1:0] busy_q, busy_d;
    logic            we_q,   we_d;
    radr_t           wadr_q, wadr_d;
    data_t           din_q,  din_d;

    regfile_wb_sched_rr_arb2 u_arb (
        .Clk         (Clk),
        .Rst         (Rst),
        .req_alu_i   (bus.AluValid),
        .req_mem_i   (bus.MemValid),
        .gnt_alu_c_o (gnt_alu),
        .gnt_mem_c_o (gnt_mem)
    );

    assign acc      = gnt_alu | gnt_mem;
    assign acc_adr  = gnt_mem ? bus.MemAdr  : bus.AluAdr;
    assign acc_data = gnt_mem ? bus.MemData : bus.AluData;

    // Hazard check sees only the current Busy; same-edge clears are not bypassed
    assign stall = bus.IssueValid && !Rst &&
                   ((bus.IssueRs1 != X0_IDX && busy_q[bus.IssueRs1]) ||
                    (bus.IssueRs2 != X0_IDX && busy_q[bus.IssueRs2]) ||
                    (bus.IssueWr && bus.IssueRd != X0_IDX && busy_q[bus.IssueRd]));

    assign issue_set = bus.IssueValid && !stall && bus.IssueWr && bus.IssueRd != X0_IDX;

    // Set is applied after clear so an issue wins over a same-edge writeback
    always_comb begin
        busy_d = busy_q;
        we_d   = 1'b0;
        wadr_d = wadr_q;
        din_d  = din_q;
        if (acc) begin
            we_d   = (acc_adr != X0_IDX);
            wadr_d = acc_adr;
            din_d  = acc_data;
            if (acc_adr != X0_IDX) begin
                busy_d[acc_adr] = 1'b0;
            end
        end
        if (issue_set) begin
            busy_d[bus.IssueRd] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            busy_q <= '0;
            we_q   <= 1'b0;
            wadr_q <= '0;
            din_q  <= '0;
        end else begin
            busy_q <= busy_d;
            we_q   <= we_d;
            wadr_q <= wadr_d;
            din_q  <= din_d;
        end
    end

    assign bus.AluReady   = gnt_alu;
    assign bus.MemReady   = gnt_mem;
    assign bus.IssueStall = stall;
    assign bus.WE         = we_q;
    assign bus.WAdr       = wadr_q;
    assign bus.Din        = din_q;
    assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with a falling-edge register-file model.
module tb_regfile_wb_sched;
    import regfile_wb_sched_pkg::*;

    logic Clk;
    logic Rst;
    int   n_cmp;
    int   n_err;
    logic [31:0] rf [32];

    regfile_wb_sched_if bus ();

    regfile_wb_sched dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file commits on the falling edge
    always @(negedge Clk) begin
        if (bus.WE) rf[bus.WAdr] <= bus.Din;
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.AluValid   = 1'b0; bus.AluAdr = '0; bus.AluData = '0;
        bus.MemValid   = 1'b0; bus.MemAdr = '0; bus.MemData = '0;
        bus.IssueValid = 1'b0; bus.IssueWr = 1'b0;
        bus.IssueRd    = '0;   bus.IssueRs1 = '0; bus.IssueRs2 = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Rst   = 1'b1;
        idle_inputs();
        tick();
        tick();

        // Reset: no grants and no stall while Rst is high
        bus.AluValid = 1'b1; bus.AluAdr = 5'd1;
        bus.MemValid = 1'b1; bus.MemAdr = 5'd2;
        #1;
        check1("rst_alu_ready", bus.AluReady, 1'b0);
        check1("rst_mem_ready", bus.MemReady, 1'b0);
        check1("rst_we", bus.WE, 1'b0);
        checkw("rst_busy", bus.Busy, 32'h0);
        checkw("rst_wadr", 32'(bus.WAdr), 32'h0);
        checkw("rst_din", bus.Din, 32'h0);
        Rst = 1'b0;
        idle_inputs();
        tick();

        // RAW: issue writes x5, then a reader of x5 stalls until the ALU writeback
        bus.IssueValid = 1'b1; bus.IssueWr = 1'b1; bus.IssueRd = 5'd5;
        #1;
        check1("raw_set_nostall", bus.IssueStall, 1'b0);
        tick();
        checkw("raw_busy5", bus.Busy, 32'h0000_0020);
        bus.IssueWr = 1'b0; bus.IssueRd = '0; bus.IssueRs1 = 5'd5;
        #1;
        check1("raw_stall_a", bus.IssueStall, 1'b1);
        tick();
        check1("raw_stall_b", bus.IssueStall, 1'b1);
        bus.AluValid = 1'b1; bus.AluAdr = 5'd5; bus.AluData = 32'h0000_1234;
        #1;
        check1("raw_alu_ready", bus.AluReady, 1'b1);
        check1("raw_stall_nobypass", bus.IssueStall, 1'b1);
        tick();
        checkw("raw_busy_clr", bus.Busy, 32'h0);
        check1("raw_we", bus.WE, 1'b1);
        checkw("raw_wadr", 32'(bus.WAdr), 32'd5);
        checkw("raw_din", bus.Din, 32'h0000_1234);
        bus.AluValid = 1'b0;
        #1;
        check1("raw_stall_released", bus.IssueStall, 1'b0);
        @(negedge Clk);
        #1;
        checkw("raw_rf_x5", rf[5], 32'h0000_1234);
        idle_inputs();
        tick();
        check1("raw_we_drop", bus.WE, 1'b0);

        // x0: accepted but never written, never marks busy, never stalls
        bus.MemValid = 1'b1; bus.MemAdr = 5'd0; bus.MemData = 32'hFFFF_FFFF;
        bus.IssueValid = 1'b1; bus.IssueWr = 1'b1; bus.IssueRd = 5'd0; bus.IssueRs1 = 5'd0;
        #1;
        check1("x0_mem_ready", bus.MemReady, 1'b1);
        check1("x0_nostall", bus.IssueStall, 1'b0);
        tick();
        check1("x0_we", bus.WE, 1'b0);
        checkw("x0_busy", bus.Busy, 32'h0);
        idle_inputs();

        // Contention: both valid for four cycles alternate ALU, MEM, ALU, MEM
        bus.AluValid = 1'b1; bus.AluAdr = 5'd3; bus.AluData = 32'hA000_0003;
        bus.MemValid = 1'b1; bus.MemAdr = 5'd4; bus.MemData = 32'hB000_0004;
        for (int i = 0; i < 4; i++) begin
            #1;
            check1("cont_alu_ready", bus.AluReady, (i % 2) == 0);
            check1("cont_mem_ready", bus.MemReady, (i % 2) == 1);
            tick();
            check1("cont_we", bus.WE, 1'b1);
            checkw("cont_wadr", 32'(bus.WAdr), ((i % 2) == 0) ? 32'd3 : 32'd4);
            checkw("cont_din", bus.Din, ((i % 2) == 0) ? 32'hA000_0003 : 32'hB000_0004);
        end
        idle_inputs();
        tick();
        check1("cont_we_off", bus.WE, 1'b0);
        checkw("cont_wadr_hold", 32'(bus.WAdr), 32'd4);

        // Same-edge clear and set of x7: set wins
        bus.AluValid = 1'b1; bus.AluAdr = 5'd7; bus.AluData = 32'h0000_0777;
        bus.IssueValid = 1'b1; bus.IssueWr = 1'b1; bus.IssueRd = 5'd7;
        #1;
        check1("setclr_alu_ready", bus.AluReady, 1'b1);
        check1("setclr_nostall", bus.IssueStall, 1'b0);
        tick();
        checkw("setclr_busy7", bus.Busy, 32'h0000_0080);
        checkw("setclr_wadr", 32'(bus.WAdr), 32'd7);
        idle_inputs();

        // WAW on x9: second writer of x9 stalls until the load writeback lands
        bus.IssueValid = 1'b1; bus.IssueWr = 1'b1; bus.IssueRd = 5'd9;
        tick();
        checkw("waw_busy9", bus.Busy, 32'h0000_0280);
        #1;
        check1("waw_stall_a", bus.IssueStall, 1'b1);
        tick();
        check1("waw_stall_b", bus.IssueStall, 1'b1);
        bus.MemValid = 1'b1; bus.MemAdr = 5'd9; bus.MemData = 32'h0000_0999;
        #1;
        check1("waw_mem_ready", bus.MemReady, 1'b1);
        check1("waw_stall_nobypass", bus.IssueStall, 1'b1);
        tick();
        checkw("waw_busy_clr", bus.Busy, 32'h0000_0080);
        bus.MemValid = 1'b0;
        #1;
        check1("waw_released", bus.IssueStall, 1'b0);
        tick();
        checkw("waw_busy_reset", bus.Busy, 32'h0000_0280);
        idle_inputs();

        // Reset in the middle of a write; priority returns to ALU
        bus.AluValid = 1'b1; bus.AluAdr = 5'd12; bus.AluData = 32'h0000_CAFE;
        #1;
        check1("mid_alu_ready", bus.AluReady, 1'b1);
        tick();
        check1("mid_we", bus.WE, 1'b1);
        Rst = 1'b1;
        bus.MemValid = 1'b1; bus.MemAdr = 5'd2; bus.MemData = 32'h0000_0002;
        bus.IssueValid = 1'b1; bus.IssueRs1 = 5'd7;
        #1;
        check1("mid_rst_alu_ready", bus.AluReady, 1'b0);
        check1("mid_rst_mem_ready", bus.MemReady, 1'b0);
        check1("mid_rst_stall", bus.IssueStall, 1'b0);
        tick();
        check1("mid_rst_we", bus.WE, 1'b0);
        checkw("mid_rst_busy", bus.Busy, 32'h0);
        checkw("mid_rst_wadr", 32'(bus.WAdr), 32'h0);
        checkw("mid_rst_din", bus.Din, 32'h0);
        Rst = 1'b0;
        #1;
        check1("mid_pri_alu", bus.AluReady, 1'b1);
        check1("mid_pri_mem", bus.MemReady, 1'b0);
        check1("mid_no_stall", bus.IssueStall, 1'b0);
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
